// File: rtl/lpf_frame_ctrl.sv
// Frame sequencer for the low-pass filter core: resets and configures the core, gates the
// input pixel stream, and checks the core's output raster flags with a stall watchdog.
module lpf_frame_ctrl #(
    parameter int unsigned XB      = 10,
    parameter int unsigned YB      = 10,
    parameter int unsigned PB      = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [XB-1:0] cfg_width,
    input  logic [YB-1:0] cfg_height,
    output logic          busy,
    output logic          frame_done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          core_rst,
    output logic [XB-1:0] core_cfg_width,
    output logic [YB-1:0] core_cfg_height,
    input  logic          src_valid,
    input  logic [PB-1:0] src_data,
    output logic          src_ready,
    output logic          core_in_valid,
    output logic [PB-1:0] core_in_data,
    input  logic          core_in_ready,
    input  logic          out_valid,
    input  logic          out_ready,
    input  logic          out_last_x,
    input  logic          out_last_y
);

    localparam int unsigned WB = $clog2(TIMEOUT + 1);
    localparam logic [WB-1:0] WdLimit = WB'(TIMEOUT);

    typedef enum logic [2:0] {StIdle, StFlush, StRun, StDone, StError} state_e;

    state_e        state_q, state_d;
    logic [1:0]    flush_q, flush_d;
    logic [XB-1:0] cfg_w_q, cfg_w_d, in_x_q, in_x_d, out_x_q, out_x_d;
    logic [YB-1:0] cfg_h_q, cfg_h_d, in_y_q, in_y_d, out_y_q, out_y_d;
    logic          in_done_q, in_done_d;
    logic [WB-1:0] wd_q, wd_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic run, in_fire, out_fire, in_end_x, in_end_y, out_end_x, out_end_y, mismatch;

    assign run       = (state_q == StRun);
    assign in_end_x  = (in_x_q == cfg_w_q);
    assign in_end_y  = (in_y_q == cfg_h_q);
    assign out_end_x = (out_x_q == cfg_w_q);
    assign out_end_y = (out_y_q == cfg_h_q);

    assign core_in_data  = src_data;
    assign core_in_valid = src_valid & run & ~in_done_q;
    assign src_ready     = core_in_ready & run & ~in_done_q;
    assign in_fire       = src_valid & src_ready;
    assign out_fire      = out_valid & out_ready & run;
    assign mismatch      = out_fire & ((out_last_x != out_end_x) | (out_last_y != out_end_y));

    assign busy            = (state_q != StIdle);
    assign frame_done      = (state_q == StDone);
    assign core_rst        = ~run;
    assign err             = err_q;
    assign err_code        = code_q;
    assign core_cfg_width  = cfg_w_q;
    assign core_cfg_height = cfg_h_q;

    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        cfg_w_d   = cfg_w_q;
        cfg_h_d   = cfg_h_q;
        in_x_d    = in_x_q;
        in_y_d    = in_y_q;
        in_done_d = in_done_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        wd_d      = wd_q;
        err_d     = err_q;
        code_d    = code_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFlush;
                    flush_d   = '0;
                    cfg_w_d   = cfg_width;
                    cfg_h_d   = cfg_height;
                    in_x_d    = '0;
                    in_y_d    = '0;
                    in_done_d = 1'b0;
                    out_x_d   = '0;
                    out_y_d   = '0;
                    wd_d      = '0;
                    err_d     = 1'b0;
                    code_d    = 2'd0;
                end
            end
            StFlush: begin
                if (abort) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end else if (flush_q == 2'd3) begin
                    state_d = StRun;
                end else begin
                    flush_d = flush_q + 2'd1;
                end
            end
            StRun: begin
                if (in_fire) begin
                    in_x_d = in_end_x ? '0 : in_x_q + 1'b1;
                    if (in_end_x) begin
                        in_y_d = in_end_y ? '0 : in_y_q + 1'b1;
                    end
                    if (in_end_x && in_end_y) begin
                        in_done_d = 1'b1;
                    end
                end
                if (out_fire) begin
                    out_x_d = out_end_x ? '0 : out_x_q + 1'b1;
                    if (out_end_x) begin
                        out_y_d = out_end_y ? '0 : out_y_q + 1'b1;
                    end
                end
                wd_d = (in_fire || out_fire) ? '0 : wd_q + 1'b1;
                // Exit priority: abort, flag mismatch, completion, watchdog.
                if (abort) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                end else if (mismatch) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                end else if (out_fire && out_end_x && out_end_y) begin
                    state_d = StDone;
                end else if (!(in_fire || out_fire) && (wd_q + 1'b1) == WdLimit) begin
                    state_d = StError;
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            flush_q   <= '0;
            cfg_w_q   <= '0;
            cfg_h_q   <= '0;
            in_x_q    <= '0;
            in_y_q    <= '0;
            in_done_q <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            wd_q      <= '0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            cfg_w_q   <= cfg_w_d;
            cfg_h_q   <= cfg_h_d;
            in_x_q    <= in_x_d;
            in_y_q    <= in_y_d;
            in_done_q <= in_done_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

endmodule

// File: tb/tb_lpf_frame_ctrl.sv
// Bench for lpf_frame_ctrl: acts as pixel source, fake filter core and host, with a pixel
// scoreboard and a per-frame outcome scoreboard.
module tb_lpf_frame_ctrl;

    localparam int XB      = 10;
    localparam int YB      = 10;
    localparam int PB      = 8;
    localparam int TIMEOUT = 1024;

    localparam int MGood     = 0;
    localparam int MBadX     = 1;
    localparam int MAbortMis = 2;
    localparam int MAbortFl  = 3;
    localparam int MWdog     = 4;
    localparam int MRst      = 5;

    logic          clk = 1'b0;
    logic          rst_n, start, abort;
    logic [XB-1:0] cfg_width, core_cfg_width;
    logic [YB-1:0] cfg_height, core_cfg_height;
    logic          busy, frame_done, err, core_rst;
    logic [1:0]    err_code;
    logic          src_valid, src_ready, core_in_valid, core_in_ready;
    logic [PB-1:0] src_data, core_in_data;
    logic          out_valid, out_ready, out_last_x, out_last_y;

    always #5 clk = ~clk;

    lpf_frame_ctrl #(.XB(XB), .YB(YB), .PB(PB), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .frame_done(frame_done), .err(err), .err_code(err_code),
        .core_rst(core_rst), .core_cfg_width(core_cfg_width), .core_cfg_height(core_cfg_height),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .core_in_valid(core_in_valid), .core_in_data(core_in_data),
        .core_in_ready(core_in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_last_x(out_last_x), .out_last_y(out_last_y)
    );

    typedef struct {
        int done;
        int err;
        int code;
    } exp_t;

    exp_t          exp_q[$];
    logic [PB-1:0] pix_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic logic [PB-1:0] pix_of(input int i);
        return PB'(i * 37 + 11);
    endfunction

    task automatic idle_inputs();
        start         = 1'b0;
        abort         = 1'b0;
        src_valid     = 1'b0;
        src_data      = '0;
        core_in_ready = 1'b0;
        out_valid     = 1'b0;
        out_ready     = 1'b0;
        out_last_x    = 1'b0;
        out_last_y    = 1'b0;
    endtask

    task automatic run_frame(input int w, input int h, input int in_pct, input int out_pct,
                             input int mode, input int k, input int exp_done,
                             input int exp_err, input int exp_code, input int budget);
        int   total = w * h;
        int   in_sent = 0, out_sent = 0, run_cnt = 0, done_cnt = 0, gate_err = 0;
        int   first_run = -1, err_cyc = -1, fault_cyc = -1, err_rst = 0, ended = 0;
        bit   run, stall, fin, fout, fault_beat;
        exp_t e;
        e.done = exp_done;
        e.err  = exp_err;
        e.code = exp_code;
        exp_q.push_back(e);
        pix_q.delete();
        for (int i = 0; i < total; i++) pix_q.push_back(pix_of(i));

        @(negedge clk);
        idle_inputs();
        start      = 1'b1;
        cfg_width  = XB'(w - 1);
        cfg_height = YB'(h - 1);
        @(posedge clk);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            rst_n = 1'b1;
            if (!busy) begin
                ended = 1;
                break;
            end
            if (frame_done) done_cnt++;
            if (err && err_cyc < 0) begin
                err_cyc = cyc;
                err_rst = int'(core_rst);
            end
            run = !core_rst;
            if (run && first_run < 0) first_run = cyc;
            stall = (mode == MWdog) && run && (run_cnt < k);
            if (run) run_cnt++;
            // Start and cfg churn while busy must not disturb the frame.
            start         = 1'($urandom_range(0, 1));
            cfg_width     = XB'($urandom);
            cfg_height    = YB'($urandom);
            src_valid     = !stall && (in_sent < total) && ($urandom_range(0, 99) < in_pct);
            src_data      = pix_of(in_sent);
            core_in_ready = $urandom_range(0, 99) < in_pct;
            out_valid     = run && !stall && (out_sent < in_sent)
                            && ($urandom_range(0, 99) < out_pct);
            out_ready     = $urandom_range(0, 99) < out_pct;
            out_last_x    = (out_sent % w) == (w - 1);
            out_last_y    = (out_sent / w) == (h - 1);
            fout          = out_valid && out_ready;
            fault_beat    = (mode == MBadX || mode == MAbortMis) && (out_sent == k);
            if (fault_beat) out_last_x = !out_last_x;
            abort = (mode == MAbortMis && fout && fault_beat) || (mode == MAbortFl && cyc == 2);
            #1;
            if (src_ready !== (core_in_ready && run && in_sent < total)) gate_err++;
            if (core_in_valid !== (src_valid && run && in_sent < total)) gate_err++;
            fin = src_valid && src_ready;
            if (fin && mode == MRst && in_sent == k) begin
                rst_n = 1'b0;
                fin   = 1'b0;
            end
            if (fin) begin
                check_eq("pix", 32'(core_in_data), 32'(pix_q.pop_front()));
                in_sent++;
            end
            if (fout) begin
                if (fault_beat) fault_cyc = cyc;
                out_sent++;
            end
            @(posedge clk);
        end
        idle_inputs();
        rst_n = 1'b1;
        check_eq("frame_ended", ended, 1);
        e = exp_q.pop_front();
        check_eq("done_pulses", done_cnt, e.done);
        check_eq("err", 32'(err), e.err);
        check_eq("err_code", 32'(err_code), e.code);
        check_eq("gating", gate_err, 0);
        if (mode != MAbortFl) check_eq("latency", first_run, 5);
        if (e.done != 0) begin
            check_eq("in_fires", in_sent, total);
            check_eq("pix_left", pix_q.size(), 0);
        end
        if (e.err != 0) check_eq("err_core_rst", err_rst, 1);
        if (mode == MBadX) check_eq("err_delay", err_cyc - fault_cyc, 1);
        check_eq("cfg_w", 32'(core_cfg_width), (mode == MRst) ? 0 : w - 1);
        check_eq("cfg_h", 32'(core_cfg_height), (mode == MRst) ? 0 : h - 1);
    endtask

    initial begin
        idle_inputs();
        rst_n      = 1'b0;
        cfg_width  = XB'(5);
        cfg_height = YB'(7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_core_rst", 32'(core_rst), 1);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_code", 32'(err_code), 0);
        check_eq("rst_cfg_w", 32'(core_cfg_width), 0);
        check_eq("rst_src_ready", 32'(src_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("idle_abort_busy", 32'(busy), 0);
        check_eq("idle_abort_err", 32'(err), 0);

        run_frame(4, 4, 100, 100, MGood, 0, 1, 0, 0, 500);
        run_frame(4, 2, 100, 100, MBadX, 2, 0, 1, 1, 500);
        // Wrong flag on the final beat outranks completion.
        run_frame(2, 2, 100, 100, MBadX, 3, 0, 1, 1, 500);
        run_frame(4, 4, 100, 100, MAbortMis, 5, 0, 1, 3, 500);
        run_frame(4, 4, 80, 70, MGood, 0, 1, 0, 0, 2000);
        run_frame(4, 4, 100, 100, MAbortFl, 0, 0, 1, 3, 500);
        run_frame(2, 2, 100, 100, MWdog, TIMEOUT, 0, 1, 2, 3000);
        run_frame(2, 2, 100, 100, MWdog, TIMEOUT - 1, 1, 0, 0, 3000);
        run_frame(4, 4, 100, 100, MRst, 9, 0, 0, 0, 500);
        run_frame(4, 4, 100, 100, MGood, 0, 1, 0, 0, 500);
        run_frame(1, 1, 100, 100, MGood, 0, 1, 0, 0, 500);
        run_frame(1024, 4, $urandom_range(50, 99), $urandom_range(50, 99), MGood, 0,
                  1, 0, 0, 60000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
